// File: rtl/ksz8851_bus_ctrl_if.sv
// Command-side and chip-bus signals of the KSZ8851 host-bus controller.
// slave = the controller; master = upstream sequencer plus pad buffers.
interface ksz8851_bus_ctrl_if;
  logic        NewCommand;
  logic        WR;
  logic [7:0]  offset;
  logic        length;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic [3:0]  state;
  logic        ETH_CSn;
  logic        ETH_CMD;
  logic        ETH_RDn;
  logic        ETH_WRn;
  logic [15:0] sd_in;
  logic [15:0] sd_out;
  logic        sd_oe;

  modport slave (
    input  NewCommand, WR, offset, length, writeData, sd_in,
    output readData, state, ETH_CSn, ETH_CMD, ETH_RDn, ETH_WRn, sd_out, sd_oe
  );

  modport master (
    output NewCommand, WR, offset, length, writeData, sd_in,
    input  readData, state, ETH_CSn, ETH_CMD, ETH_RDn, ETH_WRn, sd_out, sd_oe
  );
endinterface

// File: rtl/ksz8851_bus_ctrl.sv
// Single KSZ8851 host-bus register transaction: address phase, then read or write data phase.
// Latency: 4+2*STROBE_CYCLES cycles from the NewCommand edge to the end of Read2/Write2.
// Backpressure: NewCommand is only accepted in Wait and Read2/Write2; other requests are dropped.
module ksz8851_bus_ctrl #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic               clk40m,
  input  logic               reset,
  ksz8851_bus_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    ADDR0  = 4'd0,
    ADDR1  = 4'd1,
    ADDR2  = 4'd2,
    READ0  = 4'd3,
    READ1  = 4'd4,
    READ2  = 4'd5,
    WRITE0 = 4'd6,
    WRITE1 = 4'd7,
    WRITE2 = 4'd8,
    WAIT   = 4'd9
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] offset;
    logic       length;
  } cmd_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t      st;
  cmd_t        cmd_q;
  logic [3:0]  cnt;
  logic        csn, cmd_o, rdn, wrn, oe;
  logic [15:0] sdo, rd_q;

  function automatic logic [15:0] cmd_word(input logic [7:0] off, input logic len);
    logic [3:0] be;
    be = len ? (off[1] ? 4'b1100 : 4'b0011) : (4'b0001 << off[1:0]);
    return {be, 4'b0000, off[7:2], 2'b00};
  endfunction

  function automatic logic [15:0] write_lane(input cmd_t c, input logic [15:0] wd);
    if (c.length)
      return wd;
    return c.offset[0] ? {wd[7:0], 8'h00} : {8'h00, wd[7:0]};
  endfunction

  function automatic logic [15:0] read_lane(input cmd_t c, input logic [15:0] sd);
    if (c.length)
      return sd;
    return {8'h00, (c.offset[0] ? sd[15:8] : sd[7:0])};
  endfunction

  always_ff @(posedge clk40m) begin
    if (reset) begin
      st    <= WAIT;
      cmd_q <= '0;
      cnt   <= '0;
      csn   <= 1'b1;
      cmd_o <= 1'b0;
      rdn   <= 1'b1;
      wrn   <= 1'b1;
      oe    <= 1'b0;
      sdo   <= '0;
      rd_q  <= '0;
    end else begin
      case (st)
        // Accept points: a new command here chains straight into Addr0 with CSn kept low.
        WAIT, READ2, WRITE2: begin
          rdn <= 1'b1;
          wrn <= 1'b1;
          if (bus.NewCommand) begin
            cmd_q.wr     <= bus.WR;
            cmd_q.offset <= bus.offset;
            cmd_q.length <= bus.length;
            st    <= ADDR0;
            csn   <= 1'b0;
            cmd_o <= 1'b1;
            oe    <= 1'b1;
            sdo   <= cmd_word(bus.offset, bus.length);
          end else begin
            st    <= WAIT;
            csn   <= 1'b1;
            cmd_o <= 1'b0;
            oe    <= 1'b0;
          end
        end
        ADDR0: begin
          st  <= ADDR1;
          wrn <= 1'b0;
          cnt <= STROBE_LOAD;
        end
        ADDR1: begin
          if (cnt == 4'd0) begin
            st  <= ADDR2;
            wrn <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ADDR2: begin
          cmd_o <= 1'b0;
          if (cmd_q.wr) begin
            st  <= WRITE0;
            sdo <= write_lane(cmd_q, bus.writeData);
          end else begin
            st <= READ0;
            oe <= 1'b0;
          end
        end
        READ0: begin
          st  <= READ1;
          rdn <= 1'b0;
          cnt <= STROBE_LOAD;
        end
        READ1: begin
          if (cnt == 4'd0) begin
            st   <= READ2;
            rdn  <= 1'b1;
            rd_q <= read_lane(cmd_q, bus.sd_in);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WRITE0: begin
          st  <= WRITE1;
          wrn <= 1'b0;
          cnt <= STROBE_LOAD;
        end
        WRITE1: begin
          if (cnt == 4'd0) begin
            st  <= WRITE2;
            wrn <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          st    <= WAIT;
          csn   <= 1'b1;
          cmd_o <= 1'b0;
          rdn   <= 1'b1;
          wrn   <= 1'b1;
          oe    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state    = st;
  assign bus.ETH_CSn  = csn;
  assign bus.ETH_CMD  = cmd_o;
  assign bus.ETH_RDn  = rdn;
  assign bus.ETH_WRn  = wrn;
  assign bus.sd_oe    = oe;
  assign bus.sd_out   = sdo;
  assign bus.readData = rd_q;

endmodule
